// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: fixed-priority WB source plus round-robin among the rest,
// one registered write per cycle, and a per-register pending scoreboard for hazard queries.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_wa,
  input  logic [NREQ*DW-1:0]   req_wd,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_rd,
  input  logic [AW-1:0]        q_rs,
  input  logic [AW-1:0]        q_rt,
  output logic                 busy_rs,
  output logic                 busy_rt
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int NR = 2**AW;

  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   w_rr_nxt;
  logic [NR-1:0]   r_pending;
  logic [NR-1:0]   w_pending_nxt;
  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic [AW-1:0]   w_wa;
  logic [DW-1:0]   w_wd;
  logic            r_we_p1;
  logic [AW-1:0]   r_wa_p1;
  logic [DW-1:0]   r_wd_p1;
  int              w_cand;
  int              w_cand_nxt;

  // Stage 0: grant selection; requester 0 preempts, others rotate starting at r_rr_ptr
  always_comb begin
    w_grant    = '0;
    w_xfer     = 1'b0;
    w_rr_nxt   = r_rr_ptr;
    w_cand     = 0;
    w_cand_nxt = 0;
    if (req_valid[0]) begin
      w_grant[0] = 1'b1;
      w_xfer     = 1'b1;
    end else begin
      for (int k = 0; k < NREQ-1; k++) begin
        w_cand     = ((int'(r_rr_ptr) - 1 + k) % (NREQ-1)) + 1;
        w_cand_nxt = (w_cand == NREQ-1) ? 1 : w_cand + 1;
        if (!w_xfer && req_valid[PW'(w_cand)]) begin
          w_grant[PW'(w_cand)] = 1'b1;
          w_xfer               = 1'b1;
          w_rr_nxt             = PW'(w_cand_nxt);
        end
      end
    end
  end

  assign req_ready = w_grant;

  always_comb begin
    w_wa = '0;
    w_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_wa = req_wa[i*AW +: AW];
        w_wd = req_wd[i*DW +: DW];
      end
    end
  end

  // Clear-then-set ordering makes a same-cycle issue win over the retiring write
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_xfer && (w_wa != '0))
      w_pending_nxt[w_wa] = 1'b0;
    if (sb_set && (sb_rd != '0))
      w_pending_nxt[sb_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Stage 1: registered write toward RegFile, which commits on the following negedge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr  <= PW'(1);
      r_pending <= '0;
      r_we_p1   <= 1'b0;
      r_wa_p1   <= '0;
      r_wd_p1   <= '0;
    end else begin
      r_rr_ptr  <= w_rr_nxt;
      r_pending <= w_pending_nxt;
      r_we_p1   <= w_xfer && (w_wa != '0);
      if (w_xfer) begin
        r_wa_p1 <= w_wa;
        r_wd_p1 <= w_wd;
      end
    end
  end

  assign rf_we   = r_we_p1;
  assign rf_wa   = r_wa_p1;
  assign rf_wd   = r_wd_p1;
  assign busy_rs = r_pending[q_rs];
  assign busy_rt = r_pending[q_rt];

endmodule
